seg_scan_scheduler: RTL and testbench

Scan scheduler and write arbiter for the multiplexed seven-segment display. Holds up to four digit registers, accepts digit updates from two requesters (CPU port, debug port) under round-robin arbitration, and time-multiplexes the digits onto the shared 12-bit segment/select bundle. Each digit's on-window is separated from the next by a blanking interval. Sits between the CPU/debug logic and the board display pins.

---
 rtl/seg_pkg.sv | 59 +++++
 rtl/seg_write_arbiter.sv | 40 ++++
 rtl/seg_scan_scheduler.sv | 123 ++++++++++++
 tb/tb_seg_scan_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared field positions, constants and segment encoding
// for the multiplexed seven-segment display scanner.
package seg_pkg;

    localparam int SEG_LSB     = 0;
    localparam int DP_BIT      = 7;
    localparam int SEL_LSB     = 8;

    localparam int D_VAL_LSB   = 0;
    localparam int D_DP_BIT    = 4;
    localparam int D_BLANK_BIT = 5;

    localparam logic [11:0] ALL_OFF     = 12'hFFF;
    localparam logic [5:0]  DIGIT_BLANK = 6'h20;

    typedef enum logic {
        ST_BLANK,
        ST_ON
    } scan_state_e;

    // Active-low gfedcba for a common-anode digit
    function automatic logic [6:0] hex2seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    function automatic logic [11:0] seg_encode(
        input logic [5:0] d,
        input logic [1:0] idx
    );
        logic [11:0] o;
        o = ALL_OFF;
        o[SEL_LSB +: 4] = ~(4'b0001 << idx);
        if (!d[D_BLANK_BIT]) begin
            o[SEG_LSB +: 7] = hex2seg(d[D_VAL_LSB +: 4]);
            o[DP_BIT]       = ~d[D_DP_BIT];
        end
        return o;
    endfunction

endpackage

// File: rtl/seg_write_arbiter.sv
// Two-requester round-robin write arbiter; the pointer
// remembers which side won last so contention alternates.
module seg_write_arbiter
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_req,
    input  logic [1:0] cpu_addr,
    input  logic [5:0] cpu_data,
    input  logic       dbg_req,
    input  logic [1:0] dbg_addr,
    input  logic [5:0] dbg_data,
    output logic       cpu_gnt,
    output logic       dbg_gnt,
    output logic       wr_en_o,
    output logic [1:0] wr_addr_o,
    output logic [5:0] wr_data_o
);

    logic last_cpu_q;
    logic last_cpu_d;

    always_comb begin
        dbg_gnt    = dbg_req && (!cpu_req || last_cpu_q);
        cpu_gnt    = cpu_req && !dbg_gnt;
        wr_en_o    = cpu_gnt || dbg_gnt;
        wr_addr_o  = dbg_gnt ? dbg_addr : cpu_addr;
        wr_data_o  = dbg_gnt ? dbg_data : cpu_data;
        last_cpu_d = last_cpu_q;
        if (cpu_gnt) last_cpu_d = 1'b1;
        if (dbg_gnt) last_cpu_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_cpu_q <= 1'b0;
        else        last_cpu_q <= last_cpu_d;
    end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Digit registers, blank/on scan FSM and registered
// segment/select output for the multiplexed display.
module seg_scan_scheduler
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL_W    = 5,
    parameter int BLANK_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        cpu_req,
    input  logic [1:0]  cpu_addr,
    input  logic [5:0]  cpu_data,
    output logic        cpu_gnt,
    input  logic        dbg_req,
    input  logic [1:0]  dbg_addr,
    input  logic [5:0]  dbg_data,
    output logic        dbg_gnt,
    output logic [11:0] to_seven_seg,
    output logic [1:0]  scan_idx
);

    localparam int BLANK_W = $clog2(BLANK_CYC + 1);
    localparam int CNT_W   = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'((1 << DWELL_W) - 1);
    localparam logic [1:0]       SCAN_LAST  = 2'(NUM_DIGITS - 1);
    localparam logic [2:0]       ND         = 3'(NUM_DIGITS);

    logic       wr_en;
    logic [1:0] wr_addr;
    logic [5:0] wr_data;

    seg_write_arbiter u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .dbg_req   (dbg_req),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .cpu_gnt   (cpu_gnt),
        .dbg_gnt   (dbg_gnt),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data)
    );

    logic [5:0] dig_q [4];

    // Out-of-range writes are granted but dropped here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) dig_q[i] <= DIGIT_BLANK;
        end else if (wr_en && ({1'b0, wr_addr} < ND)) begin
            dig_q[wr_addr] <= wr_data;
        end
    end

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       scan_q, scan_d;
    logic [5:0]       latch_q, latch_d;
    logic [11:0]      out_q, out_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        scan_d  = scan_q;
        latch_d = latch_q;
        out_d   = ALL_OFF;
        if (!enable) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                        latch_d = dig_q[scan_q];
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ON: begin
                    out_d = seg_encode(latch_q, scan_q);
                    if (cnt_q == DWELL_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        scan_d  = (scan_q == SCAN_LAST) ? 2'd0 : scan_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            scan_q  <= 2'd0;
            latch_q <= DIGIT_BLANK;
            out_q   <= ALL_OFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scan_q  <= scan_d;
            latch_q <= latch_d;
            out_q   <= out_d;
        end
    end

    assign to_seven_seg = out_q;
    assign scan_idx     = scan_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Scoreboard bench: a default 4-digit scanner and a 2-digit
// build, checked against hand-computed display and grant values.
module tb_seg_scan_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        enA;
    logic        cpuA_req, dbgA_req, cpuA_gnt, dbgA_gnt;
    logic [1:0]  cpuA_addr, dbgA_addr, scanA;
    logic [5:0]  cpuA_data, dbgA_data;
    logic [11:0] segA;

    logic        cpuB_req, dbgB_req, cpuB_gnt, dbgB_gnt;
    logic [1:0]  cpuB_addr, dbgB_addr, scanB;
    logic [5:0]  cpuB_data, dbgB_data;
    logic [11:0] segB;

    seg_scan_scheduler dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enA),
        .cpu_req(cpuA_req), .cpu_addr(cpuA_addr),
        .cpu_data(cpuA_data), .cpu_gnt(cpuA_gnt),
        .dbg_req(dbgA_req), .dbg_addr(dbgA_addr),
        .dbg_data(dbgA_data), .dbg_gnt(dbgA_gnt),
        .to_seven_seg(segA), .scan_idx(scanA)
    );

    seg_scan_scheduler #(.NUM_DIGITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(1'b1),
        .cpu_req(cpuB_req), .cpu_addr(cpuB_addr),
        .cpu_data(cpuB_data), .cpu_gnt(cpuB_gnt),
        .dbg_req(dbgB_req), .dbg_addr(dbgB_addr),
        .dbg_data(dbgB_data), .dbg_gnt(dbgB_gnt),
        .to_seven_seg(segB), .scan_idx(scanB)
    );

    typedef struct {
        int          cyc;
        int          dut;
        int          kind;
        logic [11:0] val;
    } dexp_t;

    typedef struct {
        int cyc;
        int dut;
        bit cpu;
        bit dbg;
    } gexp_t;

    dexp_t dq[$];
    gexp_t gq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit run = 1'b0;
    bit done = 1'b0;
    bit reported = 1'b0;

    always @(posedge clk) if (run) cyc <= cyc + 1;

    // Monitor: pops every expectation due this cycle
    always @(negedge clk) begin
        logic [11:0] act;
        logic        gc, gd, matched;
        if (run && !reported) begin
            for (int i = dq.size() - 1; i >= 0; i--) begin
                if (dq[i].cyc == cyc) begin
                    if (dq[i].kind == 0)
                        act = (dq[i].dut == 0) ? segA : segB;
                    else
                        act = {10'd0, (dq[i].dut == 0) ? scanA : scanB};
                    checks++;
                    if (act !== dq[i].val) begin
                        failures++;
                        $display("FAIL dut%0d %s cyc=%0d got=%h want=%h",
                                 dq[i].dut, dq[i].kind == 0 ? "seg" : "scan_idx",
                                 cyc, act, dq[i].val);
                    end
                    dq.delete(i);
                end
            end
            for (int d = 0; d < 2; d++) begin
                gc = (d == 0) ? cpuA_gnt : cpuB_gnt;
                gd = (d == 0) ? dbgA_gnt : dbgB_gnt;
                matched = 1'b0;
                for (int i = gq.size() - 1; i >= 0; i--) begin
                    if (gq[i].cyc == cyc && gq[i].dut == d) begin
                        matched = 1'b1;
                        checks++;
                        if ({gc, gd} !== {gq[i].cpu, gq[i].dbg}) begin
                            failures++;
                            $display("FAIL dut%0d gnt cyc=%0d got cpu/dbg=%b%b want=%b%b",
                                     d, cyc, gc, gd, gq[i].cpu, gq[i].dbg);
                        end
                        gq.delete(i);
                    end
                end
                if (!matched) begin
                    checks++;
                    if (gc || gd) begin
                        failures++;
                        $display("FAIL dut%0d idle_gnt cyc=%0d got cpu/dbg=%b%b want=00",
                                 d, cyc, gc, gd);
                    end
                end
            end
            if (done) begin
                foreach (dq[i]) begin
                    checks++;
                    failures++;
                    $display("FAIL unchecked dut%0d cyc=%0d got=none want=%h",
                             dq[i].dut, dq[i].cyc, dq[i].val);
                end
                foreach (gq[i]) begin
                    checks++;
                    failures++;
                    $display("FAIL unseen_gnt dut%0d cyc=%0d got=none want=%b%b",
                             gq[i].dut, gq[i].cyc, gq[i].cpu, gq[i].dbg);
                end
                reported = 1'b1;
            end
        end
    end

    task automatic exp_seg(input int c, input int d, input logic [11:0] v);
        dq.push_back('{cyc: c, dut: d, kind: 0, val: v});
    endtask

    task automatic exp_scan(input int c, input int d, input logic [1:0] v);
        dq.push_back('{cyc: c, dut: d, kind: 1, val: {10'd0, v}});
    endtask

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req(input int d, input bit dbg,
                       input logic [1:0] a, input logic [5:0] v);
        gq.push_back('{cyc: cyc, dut: d, cpu: !dbg, dbg: dbg});
        if (d == 0 && !dbg) begin cpuA_req = 1; cpuA_addr = a; cpuA_data = v; end
        if (d == 0 &&  dbg) begin dbgA_req = 1; dbgA_addr = a; dbgA_data = v; end
        if (d == 1 && !dbg) begin cpuB_req = 1; cpuB_addr = a; cpuB_data = v; end
        if (d == 1 &&  dbg) begin dbgB_req = 1; dbgB_addr = a; dbgB_data = v; end
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
        cpuA_req = 0; dbgA_req = 0;
        cpuB_req = 0; dbgB_req = 0;
    endtask

    initial begin
        enA = 1;
        cpuA_req = 0; cpuA_addr = 0; cpuA_data = 0;
        dbgA_req = 0; dbgA_addr = 0; dbgA_data = 0;
        cpuB_req = 0; cpuB_addr = 0; cpuB_data = 0;
        dbgB_req = 0; dbgB_addr = 0; dbgB_data = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        run = 1;

        // Reset state and first frame of blank digits
        exp_seg(0, 0, 12'hFFF);  exp_scan(0, 0, 2'd0);
        exp_seg(0, 1, 12'hFFF);  exp_scan(0, 1, 2'd0);
        exp_seg(1, 0, 12'hFFF);  exp_seg(2, 0, 12'hFFF);
        exp_seg(3, 0, 12'hEFF);  exp_seg(20, 0, 12'hEFF);
        exp_seg(34, 0, 12'hEFF); exp_seg(35, 0, 12'hFFF);
        exp_scan(33, 0, 2'd0);   exp_scan(34, 0, 2'd1);
        exp_scan(68, 0, 2'd2);   exp_scan(102, 0, 2'd3);
        exp_scan(136, 0, 2'd0);

        // Two-digit build: out-of-range write invisible, wrap 1->0
        exp_seg(37, 1, 12'hDFF); exp_seg(71, 1, 12'hEFF);
        exp_seg(105, 1, 12'hD80); exp_seg(139, 1, 12'hEFF);
        exp_scan(34, 1, 2'd1);   exp_scan(68, 1, 2'd0);
        exp_scan(102, 1, 2'd1);

        go_to(5);
        req(0, 1, 2'd1, 6'h1A);
        req(1, 0, 2'd3, 6'h08);
        commit();
        exp_seg(37, 0, 12'hD08);

        go_to(10);
        req(0, 0, 2'd0, 6'h08);
        commit();
        exp_seg(139, 0, 12'hE80); exp_seg(170, 0, 12'hE80);
        exp_seg(171, 0, 12'hFFF);

        go_to(40);
        req(1, 1, 2'd1, 6'h08);
        commit();

        // Write during digit 1 window: shown one frame later
        go_to(50);
        req(0, 0, 2'd1, 6'h01);
        commit();
        exp_seg(65, 0, 12'hD08); exp_seg(173, 0, 12'hDF9);

        go_to(60);
        req(0, 1, 2'd3, 6'h05);
        commit();

        // Contention: alternate starting with CPU
        go_to(80);
        for (int k = 0; k < 4; k++) begin
            gq.push_back('{cyc: cyc, dut: 0, cpu: (k % 2 == 0), dbg: (k % 2 == 1)});
            cpuA_req = 1; cpuA_addr = 2'd2; cpuA_data = 6'h0C;
            dbgA_req = 1; dbgA_addr = 2'd3; dbgA_data = 6'h13;
            @(posedge clk);
            #1;
        end
        cpuA_req = 0; dbgA_req = 0;
        exp_seg(90, 0, 12'hBFF);  exp_seg(110, 0, 12'h730);
        exp_seg(207, 0, 12'hBC6);

        // Enable dropped mid-window on digit 2
        go_to(220);
        enA = 0;
        exp_seg(221, 0, 12'hFFF); exp_scan(221, 0, 2'd2);
        go_to(223);
        req(0, 1, 2'd0, 6'h00);
        commit();
        go_to(225);
        enA = 1;
        exp_seg(226, 0, 12'hFFF); exp_seg(227, 0, 12'hFFF);
        exp_seg(228, 0, 12'hBC6); exp_seg(259, 0, 12'hBC6);
        exp_seg(260, 0, 12'hFFF);
        exp_scan(258, 0, 2'd2);  exp_scan(259, 0, 2'd3);
        exp_seg(262, 0, 12'h730);

        go_to(270);
        done = 1;
        for (int k = 0; k < 4 && !reported; k++) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
